pulse_stretch_sched: RTL and testbench

PULSE_STRETCH_SCHED -- requirements
Module: pulse_stretch_sched

---
 rtl/pulse_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/pulse_stretch_sched.sv | 130 +++++++++++++
 tb/tb_pulse_stretch_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sched_pkg.sv
// rtl/pulse_sched_pkg.sv - shared FSM encoding and parameter defaults for pulse_stretch_sched
package pulse_sched_pkg;

  localparam int DEF_N       = 32;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LAUNCH     = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_END   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, search starts just above ptr
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         pending,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic                    valid
);

  logic [NREQ-1:0] above;
  logic [NREQ-1:0] src;

  always_comb begin
    // Requests strictly above the last served index get first chance; otherwise wrap.
    above = pending & ({NREQ{1'b1}} << ptr) & ~(NREQ'(1) << ptr);
    src   = (above != '0) ? above : pending;
    gnt   = src & (~src + NREQ'(1));
    valid = |pending;
  end

endmodule

// File: rtl/pulse_stretch_sched.sv
// rtl/pulse_stretch_sched.sv - round-robin scheduler feeding a single pulse stretcher
// Optional watchdog abort enabled by defining PULSE_SCHED_TIMEOUT_EN.
module pulse_stretch_sched
  import pulse_sched_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              wr_clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] len,
  input  logic              pulse_en,
  output logic              pulse,
  output logic [N-1:0]      pulse_len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   pending,
  output logic              err
);

  localparam int PW = $clog2(NREQ);

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, cur_idx;
  logic [NREQ-1:0] arb_gnt, gnt_n, done_n, pending_n;
  logic            arb_valid, pulse_n, finish, abort;
  logic [N-1:0]    len_pick, len_n;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .pending (pending),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .valid   (arb_valid)
  );

  always_comb begin
    len_pick = '0;
    cur_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) len_pick = len[i*N +: N];
      if (gnt[i])     cur_idx  = PW'(i);
    end
  end

`ifdef PULSE_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          in_wait;

  assign in_wait = (state == ST_WAIT_START) || (state == ST_WAIT_END);
  assign abort   = in_wait && (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= in_wait ? wd_cnt + 1'b1 : '0;
      err    <= abort;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign abort          = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    len_n   = pulse_len;
    ptr_n   = ptr;
    pulse_n = 1'b0;
    done_n  = '0;
    finish  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_n   = arb_gnt;
          len_n   = len_pick;
          state_n = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // A zero-length request completes here without touching the stretcher.
        if (pulse_len == '0) begin
          finish = 1'b1;
        end else begin
          pulse_n = 1'b1;
          state_n = ST_WAIT_START;
        end
      end
      ST_WAIT_START: if (pulse_en) state_n = ST_WAIT_END;
      ST_WAIT_END:   if (!pulse_en) finish = 1'b1;
      default:       state_n = ST_IDLE;
    endcase
    if (finish || abort) begin
      done_n  = gnt;
      gnt_n   = '0;
      ptr_n   = cur_idx;
      state_n = ST_IDLE;
    end
    // A new strobe in the completion cycle keeps the request outstanding.
    pending_n = (pending & ~done_n) | req;
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pending   <= '0;
      gnt       <= '0;
      done      <= '0;
      pulse     <= 1'b0;
      pulse_len <= '0;
      ptr       <= PW'(NREQ - 1);
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      gnt       <= gnt_n;
      done      <= done_n;
      pulse     <= pulse_n;
      pulse_len <= len_n;
      ptr       <= ptr_n;
    end
  end

endmodule

// File: tb/tb_pulse_stretch_sched.sv
// tb/tb_pulse_stretch_sched.sv - randomized and directed bench with a behavioural scheduler model
module tb_pulse_stretch_sched;

  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic              wr_clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] len;
  logic              pulse_en;
  logic              pulse;
  logic [N-1:0]      pulse_len;
  logic [NREQ-1:0]   gnt, done, pending;
  logic              err;

  pulse_stretch_sched #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .wr_clk    (wr_clk),
    .reset     (reset),
    .req       (req),
    .len       (len),
    .pulse_en  (pulse_en),
    .pulse     (pulse),
    .pulse_len (pulse_len),
    .gnt       (gnt),
    .done      (done),
    .pending   (pending),
    .err       (err)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: service phase 0 idle, 1 granted, 2 awaiting stretcher start, 3 awaiting end.
  int              m_phase = 0;
  int              m_cur   = -1;
  int              m_ptr   = NREQ - 1;
  int              m_wd    = 0;
  logic [NREQ-1:0] m_pend  = '0;
  logic [NREQ-1:0] e_gnt   = '0;
  logic [NREQ-1:0] e_done  = '0;
  logic            e_pulse = 1'b0;
  logic            e_err   = 1'b0;
  logic [N-1:0]    e_len   = '0;

  task automatic model_step();
    bit fin, hit;
    if (reset) begin
      m_phase = 0; m_cur = -1; m_ptr = NREQ - 1; m_wd = 0;
      m_pend = '0; e_gnt = '0; e_done = '0; e_pulse = 0; e_err = 0; e_len = '0;
      return;
    end
    fin = 0; hit = 0; e_pulse = 0; e_err = 0; e_done = '0;
    case (m_phase)
      0: begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (m_pend[c] && m_cur < 0) begin
            m_cur = c; e_gnt = '0; e_gnt[c] = 1'b1; e_len = len[c*N +: N]; m_phase = 1;
          end
        end
      end
      1: begin
        if (e_len == 0) fin = 1;
        else begin e_pulse = 1; m_phase = 2; m_wd = 0; end
      end
      default: begin
`ifdef PULSE_SCHED_TIMEOUT_EN
        m_wd++;
        hit = (m_wd == TIMEOUT);
`endif
        if (hit) begin fin = 1; e_err = 1; end
        else if (m_phase == 2 && pulse_en) m_phase = 3;
        else if (m_phase == 3 && !pulse_en) fin = 1;
      end
    endcase
    if (fin) begin
      e_done = e_gnt; m_pend = m_pend & ~e_gnt; e_gnt = '0;
      m_ptr = m_cur; m_cur = -1; m_phase = 0;
    end
    m_pend = m_pend | req;
  endtask

  // Bench-side stretcher: random start delay, then high for pulse_len cycles.
  bit auto_on = 0;
  int sw = 0, sr = 0;

  task automatic tick();
    @(posedge wr_clk);
    model_step();
    @(negedge wr_clk);
    check_eq("pending", pending, m_pend);
    check_eq("gnt", gnt, e_gnt);
    check_eq("pulse", pulse, e_pulse);
    check_eq("done", done, e_done);
    check_eq("pulse_len", pulse_len, e_len);
    check_eq("err", err, e_err);
    if (auto_on) begin
      if (pulse) begin sw = $urandom_range(0, 2); sr = int'(pulse_len); end
      if (sw > 0) begin sw--; pulse_en = 0; end
      else if (sr > 0) begin sr--; pulse_en = 1; end
      else pulse_en = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1; req = '0; pulse_en = 0; auto_on = 0; sw = 0; sr = 0;
    tick();
    reset = 0;
  endtask

  task automatic wait_pulse();
    bit seen;
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      seen = pulse;
    end
    if (!seen) check_eq("pulse_seen", 0, 1);
  endtask

  initial begin
    int order[$];
    int cnt, first;
    logic [NREQ-1:0] done_at;
    reset = 1; req = '0; len = '0; pulse_en = 0;
    @(negedge wr_clk);
    tick(); tick();
    reset = 0;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_pulse", pulse, 0);
    check_eq("rst_done", done, 0);

    // Single request, exact latency
    do_reset();
    len[1*N +: N] = 20; req = 4'b0010;
    tick(); req = '0;
    check_eq("lat_pending", pending, 4'b0010);
    tick();
    check_eq("lat_gnt", gnt, 4'b0010);
    tick();
    check_eq("lat_pulse", pulse, 1);
    check_eq("lat_len", pulse_len, 20);
    tick();
    pulse_en = 1;
    for (int k = 0; k < 20; k++) tick();
    pulse_en = 0;
    tick();
    check_eq("single_done", done, 4'b0010);

    // Fairness
    do_reset();
    for (int i = 0; i < NREQ; i++) len[i*N +: N] = 5;
    req = 4'b1111;
    tick(); req = '0; auto_on = 1;
    for (int k = 0; k < 200 && order.size() < 4; k++) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (done[i]) order.push_back(i);
    end
    tick();
    check_eq("fair_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) check_eq("fair_order", order[i], i);
    check_eq("fair_pending", pending, 0);

    // Re-request during service
    do_reset();
    len[2*N +: N] = 3; req = 4'b0100;
    tick(); req = '0;
    wait_pulse();
    pulse_en = 1; tick();
    req = 4'b0100; tick();
    req = '0; tick();
    req = 4'b0100; pulse_en = 0; tick();
    req = '0;
    check_eq("rereq_done", done, 4'b0100);
    check_eq("rereq_pending", pending, 4'b0100);
    auto_on = 1; cnt = 0;
    for (int k = 0; k < 40; k++) begin tick(); if (done[2]) cnt++; end
    check_eq("rereq_served", cnt, 1);
    check_eq("rereq_idle", pending, 0);

    // Zero length
    do_reset();
    len[0 +: N] = 0; req = 4'b0001;
    tick(); req = '0;
    tick();
    check_eq("zero_gnt", gnt, 4'b0001);
    tick();
    check_eq("zero_done", done, 4'b0001);
    check_eq("zero_nopulse", pulse, 0);
    check_eq("zero_gnt_clr", gnt, 0);

    // Reset mid-service
    do_reset();
    len[1*N +: N] = 10; req = 4'b0010;
    tick(); req = '0;
    wait_pulse();
    pulse_en = 1; tick();
    req = 4'b0100; tick(); req = '0;
    check_eq("mid_pending", pending, 4'b0110);
    reset = 1; pulse_en = 0; tick(); reset = 0;
    check_eq("mid_gnt", gnt, 0);
    check_eq("mid_pend0", pending, 0);
    check_eq("mid_done", done, 0);
    check_eq("mid_err", err, 0);
    check_eq("mid_len", pulse_len, 0);
    len[3*N +: N] = 5; req = 4'b1000;
    tick(); req = '0;
    tick();
    check_eq("mid_next_gnt", gnt, 4'b1000);

    // Stretcher never starts
    do_reset();
    len[0 +: N] = 4; req = 4'b0001;
    tick(); req = '0;
    wait_pulse();
    first = -1; done_at = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (err && first < 0) begin first = k; done_at = done; end
    end
`ifdef PULSE_SCHED_TIMEOUT_EN
    check_eq("wd_cycles", first, TIMEOUT);
    check_eq("wd_done", done_at, 4'b0001);
`else
    check_eq("nowd_err", first, -1);
    check_eq("nowd_gnt", gnt, 4'b0001);
`endif

    // Random traffic
    do_reset();
    auto_on = 1;
    for (int k = 0; k < 3000; k++) begin
      req = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
      for (int i = 0; i < NREQ; i++) len[i*N +: N] = N'($urandom_range(0, 6));
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 0; req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
